// File: rtl/if_fetch_if.sv
// if_fetch_if: memory request/response and decode-side signals of the fetch stage.
interface if_fetch_if;
  logic        br;
  logic [31:0] br_addr;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  modport master (
    input  br, br_addr, stall, mem_rvalid, mem_rdata,
    output mem_req, mem_addr, id_valid, id_pc, id_inst
  );
  modport slave (
    output br, br_addr, stall, mem_rvalid, mem_rdata,
    input  mem_req, mem_addr, id_valid, id_pc, id_inst
  );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: single-outstanding instruction fetch with redirect, stall and a one-entry hold buffer.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic        clk,
  input logic        rst,
  if_fetch_if.master bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DISCARD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] hb_pc_q, hb_pc_d;
  logic [31:0] hb_inst_q, hb_inst_d;
  logic        busy, br_ok, req, rsp, dlv_mem, dlv_hb, cap;
  // a redirect only counts when decode is consuming the instruction it refers to
  assign busy    = id_valid_q && bus.stall;
  assign br_ok   = bus.br && id_valid_q && !bus.stall;
  assign req     = (state_q == ISSUE) && !busy;
  assign rsp     = (state_q == WAIT) && bus.mem_rvalid;
  assign dlv_mem = rsp && !br_ok && !busy;
  assign dlv_hb  = (state_q == HOLD) && !bus.stall && !br_ok;
  assign cap     = rsp && !br_ok && busy;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ISSUE;
      ISSUE:   state_d = req ? (br_ok ? DISCARD : WAIT) : ISSUE;
      WAIT:    state_d = !bus.mem_rvalid ? (br_ok ? DISCARD : WAIT) : (cap ? HOLD : ISSUE);
      HOLD:    state_d = bus.stall ? HOLD : ISSUE;
      DISCARD: state_d = bus.mem_rvalid ? ISSUE : DISCARD;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    pc_d       = br_ok ? {bus.br_addr[31:2], 2'b00} : rsp ? pc_q + 32'd4 : pc_q;
    id_valid_d = dlv_mem || dlv_hb || busy;
    id_pc_d    = dlv_mem ? pc_q : dlv_hb ? hb_pc_q : id_pc_q;
    id_inst_d  = dlv_mem ? bus.mem_rdata : dlv_hb ? hb_inst_q : id_inst_q;
    hb_pc_d    = cap ? pc_q : hb_pc_q;
    hb_inst_d  = cap ? bus.mem_rdata : hb_inst_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      hb_pc_q    <= '0;
      hb_inst_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      hb_pc_q    <= hb_pc_d;
      hb_inst_q  <= hb_inst_d;
    end
  end
  always_comb begin
    bus.mem_req  = req;
    bus.mem_addr = pc_q;
    bus.id_valid = id_valid_q;
    bus.id_pc    = id_pc_q;
    bus.id_inst  = id_inst_q;
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed checks of if_fetch against a memory returning ~addr after lat cycles.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst0, rst1;
  int          n_cmp = 0, n_bad = 0;
  int          lat = 1, cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] pa = '0;
  if_fetch_if b0 ();
  if_fetch_if b1 ();
  if_fetch dut0 (.clk(clk), .rst(rst0), .bus(b0));
  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (.clk(clk), .rst(rst1), .bus(b1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // one clock for dut0 with the memory model answering the request seen before the edge
  task automatic tick();
    logic        r;
    logic [31:0] a;
    r = b0.mem_req;
    a = b0.mem_addr;
    @(posedge clk);
    #1;
    b0.mem_rvalid = 1'b0;
    if (r) begin pend = 1'b1; pa = a; cnt = lat; end
    if (pend) begin
      if (cnt <= 1) begin b0.mem_rvalid = 1'b1; b0.mem_rdata = ~pa; pend = 1'b0; end
      else cnt--;
    end
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst0 = 1'b0; rst1 = 1'b0;
    b0.br = 1'b0; b0.br_addr = '0; b0.stall = 1'b0;
    b0.mem_rvalid = 1'b1; b0.mem_rdata = 32'h1234_5678;
    b1.br = 1'b0; b1.br_addr = '0; b1.stall = 1'b0;
    b1.mem_rvalid = 1'b0; b1.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", b0.mem_req, 0);
    chk("rst_addr", b0.mem_addr, 0);
    chk("rst_vld", b0.id_valid, 0);
    chk("rst_pc", b0.id_pc, 0);
    chk("rst_inst", b0.id_inst, 0);
    rst0 = 1'b1;
    #1;
    chk("idle_req", b0.mem_req, 0);
    tick();
    chk("boot_req", b0.mem_req, 1);
    chk("boot_addr", b0.mem_addr, 32'h0);
    chk("idle_rvalid_ign", b0.id_valid, 0);
    tick();
    chk("wait_noreq", b0.mem_req, 0);
    tick();
    chk("d0_vld", b0.id_valid, 1);
    chk("d0_pc", b0.id_pc, 32'h0);
    chk("d0_inst", b0.id_inst, 32'hFFFF_FFFF);
    chk("d0_req", b0.mem_req, 1);
    chk("d0_next", b0.mem_addr, 32'h4);
    tick();
    chk("gap_vld", b0.id_valid, 0);
    chk("gap_pc_keep", b0.id_pc, 32'h0);
    tick();
    chk("d1_pc", b0.id_pc, 32'h4);
    chk("d1_inst", b0.id_inst, 32'hFFFF_FFFB);
    chk("d1_next", b0.mem_addr, 32'h8);
    tick(); tick();
    chk("d2_vld", b0.id_valid, 1);
    chk("d2_pc", b0.id_pc, 32'h8);
    chk("d2_inst", b0.id_inst, 32'hFFFF_FFF7);
    b0.stall = 1'b1; b0.br = 1'b1; b0.br_addr = 32'h200;
    #1;
    chk("stall_noreq0", b0.mem_req, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_vld", b0.id_valid, 1);
      chk("stall_pc", b0.id_pc, 32'h8);
      chk("stall_noreq", b0.mem_req, 0);
    end
    b0.stall = 1'b0; b0.br = 1'b0;
    #1;
    chk("unstall_req", b0.mem_req, 1);
    chk("br_stall_ign", b0.mem_addr, 32'hC);
    tick(); tick();
    chk("d3_pc", b0.id_pc, 32'hC);
    chk("d3_inst", b0.id_inst, 32'hFFFF_FFF3);
    b0.br = 1'b1; b0.br_addr = 32'h103;
    #1;
    tick();
    b0.br = 1'b0;
    chk("br_vld", b0.id_valid, 0);
    chk("br_noreq", b0.mem_req, 0);
    chk("br_addr_align", b0.mem_addr, 32'h100);
    tick();
    chk("drop_vld", b0.id_valid, 0);
    chk("drop_pc", b0.id_pc, 32'hC);
    chk("br_req", b0.mem_req, 1);
    chk("br_target", b0.mem_addr, 32'h100);
    tick(); tick();
    chk("d4_pc", b0.id_pc, 32'h100);
    chk("d4_inst", b0.id_inst, 32'hFFFF_FEFF);
    lat = 3;
    b0.br = 1'b1; b0.br_addr = 32'h40;
    #1;
    tick();
    b0.br = 1'b0;
    tick();
    chk("disc_noreq", b0.mem_req, 0);
    chk("disc_vld", b0.id_valid, 0);
    tick(); tick();
    chk("disc_req", b0.mem_req, 1);
    chk("disc_addr", b0.mem_addr, 32'h40);
    chk("disc_pc_keep", b0.id_pc, 32'h100);
    tick(); tick();
    chk("slow_noreq", b0.mem_req, 0);
    chk("slow_vld", b0.id_valid, 0);
    tick(); tick();
    chk("d5_pc", b0.id_pc, 32'h40);
    chk("d5_inst", b0.id_inst, 32'hFFFF_FFBF);
    rst0 = 1'b0;
    #1;
    chk("arst_vld", b0.id_valid, 0);
    chk("arst_pc", b0.id_pc, 0);
    chk("arst_inst", b0.id_inst, 0);
    chk("arst_req", b0.mem_req, 0);
    chk("arst_addr", b0.mem_addr, 0);
    pend = 1'b0; lat = 1;
    tick();
    rst0 = 1'b1;
    #1;
    chk("rel_noreq", b0.mem_req, 0);
    tick();
    chk("rel_req", b0.mem_req, 1);
    chk("rel_addr", b0.mem_addr, 0);
    tick(); tick();
    chk("rel_d_pc", b0.id_pc, 0);
    chk("rel_d_inst", b0.id_inst, 32'hFFFF_FFFF);
    rst1 = 1'b1;
    #1;
    chk("w_noreq", b1.mem_req, 0);
    @(posedge clk); #1;
    chk("w_req", b1.mem_req, 1);
    chk("w_addr", b1.mem_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    b1.mem_rvalid = 1'b1; b1.mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    b1.mem_rvalid = 1'b0;
    chk("w_vld", b1.id_valid, 1);
    chk("w_pc", b1.id_pc, 32'hFFFF_FFFC);
    chk("w_inst", b1.id_inst, 32'hCAFE_F00D);
    chk("w_wrap", b1.mem_addr, 32'h0);
    rst1 = 1'b0;
    #1;
    chk("w_arst_vld", b1.id_valid, 0);
    chk("w_arst_addr", b1.mem_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    rst1 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("w_wait_noreq", b1.mem_req, 0);
    rst1 = 1'b0;
    b1.mem_rvalid = 1'b1; b1.mem_rdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    b1.mem_rvalid = 1'b0;
    rst1 = 1'b1;
    @(posedge clk); #1;
    chk("w_rst_vld", b1.id_valid, 0);
    chk("w_rst_req", b1.mem_req, 1);
    chk("w_rst_addr", b1.mem_addr, 32'hFFFF_FFFC);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
